mips_fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS soft processor, directly upstream of the instruction memory. Holds the byte program counter, drives the word address into the instruction memory, captures the returned instruction into the IF/ID pipeline register, and handles start, stall, branch/jump redirect, halt and out-of-range fetch faults. The decode stage consumes the IF/ID outputs.

---
 rtl/mips_fetch_unit.sv | 96 +++++++++
 tb/tb_mips_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: owns the byte PC, addresses instruction memory and
// registers the returned word into the IF/ID pipeline register.
module mips_fetch_unit #(
  parameter int n_bit       = 31,
  parameter int memory_size = 2047,
  parameter int reset_pc    = 0
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic             in_stall,
  input  logic             in_redirect_valid,
  input  logic [n_bit:0]   in_redirect_pc,
  input  logic             in_halt,
  input  logic [n_bit:0]   in_imem_instr,
  output logic [n_bit:0]   out_imem_addr,
  output logic [n_bit:0]   out_if_instr,
  output logic [n_bit:0]   out_if_pc_plus4,
  output logic             out_if_valid,
  output logic [n_bit:0]   out_fetch_count,
  output logic             out_halted,
  output logic             out_fault
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [n_bit:0] PC_INIT = (n_bit+1)'(reset_pc) & ~(n_bit+1)'(3);
  localparam logic [n_bit:0] MEM_MAX = (n_bit+1)'(memory_size);
  localparam logic [n_bit:0] FOUR    = (n_bit+1)'(4);
  localparam logic [n_bit:0] ONE     = (n_bit+1)'(1);

  logic [1:0]     state_p0;
  logic [n_bit:0] pc_p0;
  logic [n_bit:0] word_idx;
  logic [n_bit:0] pc_plus4;
  logic           out_of_range;

  function automatic logic [n_bit:0] word_align(input logic [n_bit:0] byte_addr);
    return {byte_addr[n_bit:2], 2'b00};
  endfunction

  assign word_idx      = {2'b00, pc_p0[n_bit:2]};
  assign pc_plus4      = pc_p0 + FOUR;
  assign out_of_range  = (word_idx > MEM_MAX);
  assign out_imem_addr = word_idx;
  assign out_halted    = (state_p0 == HALTED);

  // IF/ID boundary: memory response is registered alongside its PC+4
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_p0        <= IDLE;
      pc_p0           <= PC_INIT;
      out_if_instr    <= '0;
      out_if_pc_plus4 <= '0;
      out_if_valid    <= 1'b0;
      out_fetch_count <= '0;
      out_fault       <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (in_start) state_p0 <= RUN;
        end
        RUN: begin
          // Redirect comes from an older instruction, so it outranks halt/fault
          if (in_redirect_valid) begin
            pc_p0        <= word_align(in_redirect_pc);
            out_if_instr <= '0;
            out_if_valid <= 1'b0;
          end else if (in_halt) begin
            state_p0     <= HALTED;
            out_if_instr <= '0;
            out_if_valid <= 1'b0;
          end else if (out_of_range) begin
            state_p0     <= HALTED;
            out_fault    <= 1'b1;
            out_if_instr <= '0;
            out_if_valid <= 1'b0;
          end else if (!in_stall) begin
            out_if_instr    <= in_imem_instr;
            out_if_pc_plus4 <= pc_plus4;
            out_if_valid    <= 1'b1;
            pc_p0           <= pc_plus4;
            out_fetch_count <= out_fetch_count + ONE;
          end
        end
        default: begin
          state_p0     <= HALTED;
          out_if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit against a memory whose word i holds
// 0x1000_0000 + i.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic        halted;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb imem_instr = 32'h1000_0000 + imem_addr;

  mips_fetch_unit #(.n_bit(31), .memory_size(2047), .reset_pc(0)) dut (
    .in_clk            (clk),
    .in_rst_n          (rst_n),
    .in_start          (start),
    .in_stall          (stall),
    .in_redirect_valid (redirect_valid),
    .in_redirect_pc    (redirect_pc),
    .in_halt           (halt),
    .in_imem_instr     (imem_instr),
    .out_imem_addr     (imem_addr),
    .out_if_instr      (if_instr),
    .out_if_pc_plus4   (if_pc_plus4),
    .out_if_valid      (if_valid),
    .out_fetch_count   (fetch_count),
    .out_halted        (halted),
    .out_fault         (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic [31:0] cnt);
    check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    check({tag, "_instr"}, if_instr, instr);
    check({tag, "_pc4"}, if_pc_plus4, pc4);
    check({tag, "_count"}, fetch_count, cnt);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    tick(); tick();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc4", if_pc_plus4, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);

    // Idle ignores stall/redirect/halt
    rst_n = 1'b1; halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    halt = 1'b0; redirect_valid = 1'b0;
    check("idle_addr", imem_addr, 32'd0);
    check("idle_halted", {31'd0, halted}, 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_valid", {31'd0, if_valid}, 32'd0);
    tick(); check_if("f0", 32'h1000_0000, 32'd4, 32'd1);
    tick(); check_if("f1", 32'h1000_0001, 32'd8, 32'd2);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_if("stall", 32'h1000_0001, 32'd8, 32'd2);
    end
    stall = 1'b0;
    tick(); check_if("f2", 32'h1000_0002, 32'd12, 32'd3);

    // Redirect beats stall, one bubble
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    check("redir_bubble", {31'd0, if_valid}, 32'd0);
    check("redir_flush", if_instr, 32'd0);
    check("redir_addr", imem_addr, 32'h10);
    tick(); check_if("redir_tgt", 32'h1000_0010, 32'h44, 32'd4);

    // Halt together with redirect follows the redirect
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    halt = 1'b0; redirect_valid = 1'b0;
    check("hr_halted", {31'd0, halted}, 32'd0);
    check("hr_addr", imem_addr, 32'h40);
    tick(); check_if("hr_tgt", 32'h1000_0040, 32'h104, 32'd5);

    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, if_valid}, 32'd0);
    check("halt_count", fetch_count, 32'd5);
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick(); tick();
    start = 1'b0; redirect_valid = 1'b0;
    check("halted_hold", {31'd0, halted}, 32'd1);
    check("halted_addr", imem_addr, 32'h41);
    check("halted_count", fetch_count, 32'd5);
    check("halted_valid", {31'd0, if_valid}, 32'd0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("hrst_halted", {31'd0, halted}, 32'd0);
    check("hrst_addr", imem_addr, 32'd0);
    check("hrst_count", fetch_count, 32'd0);
    tick();
    check("hrst_idle", {31'd0, if_valid}, 32'd0);

    // Out-of-range fetch faults
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); check_if("r0", 32'h1000_0000, 32'd4, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h2000;
    tick();
    redirect_valid = 1'b0;
    check("oor_addr", imem_addr, 32'h800);
    check("oor_pre_halted", {31'd0, halted}, 32'd0);
    tick();
    check("oor_fault", {31'd0, fault}, 32'd1);
    check("oor_halted", {31'd0, halted}, 32'd1);
    check("oor_valid", {31'd0, if_valid}, 32'd0);
    check("oor_count", fetch_count, 32'd1);

    // Word 2047 is still in range
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("frst_fault", {31'd0, fault}, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h1FFC; tick(); redirect_valid = 1'b0;
    tick(); check_if("last_word", 32'h1000_07FF, 32'h2000, 32'd1);
    check("last_fault", {31'd0, fault}, 32'd0);

    // Reset mid-stream wins over other inputs
    tick(); tick();
    check("pre_rst_fault", {31'd0, fault}, 32'd1);
    rst_n = 1'b0; start = 1'b1; halt = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0; halt = 1'b0;
    check("mrst_valid", {31'd0, if_valid}, 32'd0);
    check("mrst_instr", if_instr, 32'd0);
    check("mrst_pc4", if_pc_plus4, 32'd0);
    check("mrst_count", fetch_count, 32'd0);
    check("mrst_fault", {31'd0, fault}, 32'd0);
    check("mrst_halted", {31'd0, halted}, 32'd0);
    check("mrst_addr", imem_addr, 32'd0);
    tick();
    check("mrst_idle_valid", {31'd0, if_valid}, 32'd0);
    check("mrst_idle_count", fetch_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
